// File: rtl/dragon_move_sched_if.sv
// Signal bundle between the dragon behaviour FSM (master) and the move scheduler (slave).
// Latency: wires only; timing is set by the scheduler itself.
// Backpressure: none; outputs are levels or single-cycle pulses, inputs are sampled when needed.
interface dragon_move_sched_if #(
  parameter int COORD_W = 4,
  parameter int MAX_LEN = 8
);
  localparam int SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Control and targets from the behaviour side
  logic               enable;
  logic               frame_tick;
  logic [1:0]         mode;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic [COORD_W-1:0] sheep_x;
  logic [COORD_W-1:0] sheep_y;
  logic [SEL_W-1:0]   seg_sel;

  // Dragon state and events toward renderer/collision
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [1:0]         dir;
  logic [LEN_W-1:0]   length;
  logic [COORD_W-1:0] seg_x;
  logic [COORD_W-1:0] seg_y;
  logic               step_valid;
  logic               ate_sheep;
  logic               hit_player;

  modport master (
    output enable, frame_tick, mode, player_x, player_y, sheep_x, sheep_y, seg_sel,
    input  head_x, head_y, dir, length, seg_x, seg_y, step_valid, ate_sheep, hit_player
  );

  modport slave (
    input  enable, frame_tick, mode, player_x, player_y, sheep_x, sheep_y, seg_sel,
    output head_x, head_y, dir, length, seg_x, seg_y, step_valid, ate_sheep, hit_player
  );
endinterface

// File: rtl/dragon_move_sched.sv
// Dragon movement scheduler: divides frame ticks to a step rate, then moves, grows or holds the dragon.
// Latency: a step or grow lands two edges after the MOVE_DIV-th tick; step_valid pulses with the new head.
// Backpressure: none; ticks arriving during STEP/GROW are ignored, enable low freezes everything.
module dragon_move_sched #(
  parameter int COORD_W  = 4,
  parameter int MAX_LEN  = 8,
  parameter int MOVE_DIV = 4,
  parameter int START_X  = 0,
  parameter int START_Y  = 0
) (
  input logic                clk,
  input logic                rst,
  dragon_move_sched_if.slave bus
);
  localparam int SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, STEP, GROW} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [COORD_W-1:0] head_x_q;
  logic [COORD_W-1:0] head_y_q;
  logic [1:0]         dir_q;
  logic [LEN_W-1:0]   length_q;
  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic               step_valid_q;
  logic               ate_sheep_q;
  logic               hit_player_q;

  logic               has_tgt;
  logic [COORD_W-1:0] tgt_x;
  logic [COORD_W-1:0] tgt_y;
  logic               do_move;
  logic [COORD_W-1:0] nxt_x;
  logic [COORD_W-1:0] nxt_y;
  logic [1:0]         nxt_dir;
  logic [SEL_W-1:0]   tail_idx;
  logic [SEL_W-1:0]   last_idx;
  logic               seg_in_range;

  // Pick the chase target for the current mode and work out the one-tile move toward it (X first, then Y).
  always_comb begin
    has_tgt = 1'b0;
    tgt_x   = '0;
    tgt_y   = '0;
    case (bus.mode)
      2'b00: begin
        has_tgt = 1'b1;
        tgt_x   = bus.player_x;
        tgt_y   = bus.player_y;
      end
      2'b01: begin
        has_tgt = 1'b1;
        tgt_x   = bus.sheep_x;
        tgt_y   = bus.sheep_y;
      end
      default: begin
        has_tgt = 1'b0;
      end
    endcase

    do_move = 1'b0;
    nxt_x   = head_x_q;
    nxt_y   = head_y_q;
    nxt_dir = dir_q;
    if (has_tgt) begin
      if (head_x_q != tgt_x) begin
        do_move = 1'b1;
        if (tgt_x > head_x_q) begin
          nxt_x   = head_x_q + COORD_W'(1);
          nxt_dir = 2'b00;
        end else begin
          nxt_x   = head_x_q - COORD_W'(1);
          nxt_dir = 2'b01;
        end
      end else if (head_y_q != tgt_y) begin
        do_move = 1'b1;
        if (tgt_y > head_y_q) begin
          nxt_y   = head_y_q + COORD_W'(1);
          nxt_dir = 2'b10;
        end else begin
          nxt_y   = head_y_q - COORD_W'(1);
          nxt_dir = 2'b11;
        end
      end
    end
  end

  // Slot that a grow fills, and the current last body slot it copies from (only used when length > 0).
  assign tail_idx = SEL_W'(length_q);
  assign last_idx = SEL_W'(length_q - LEN_W'(1));

  // Scheduler FSM: divider, head/segment updates and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_q        <= '0;
      head_x_q     <= COORD_W'(START_X);
      head_y_q     <= COORD_W'(START_Y);
      dir_q        <= 2'b00;
      length_q     <= '0;
      step_valid_q <= 1'b0;
      ate_sheep_q  <= 1'b0;
      hit_player_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
    end else begin
      step_valid_q <= 1'b0;
      ate_sheep_q  <= 1'b0;
      hit_player_q <= 1'b0;
      if (!bus.enable) begin
        // Freeze: position and body hold, the step count restarts on re-enable
        state <= IDLE;
        div_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT;
          end
          WAIT: begin
            if (bus.frame_tick) begin
              if (div_q == DIV_W'(MOVE_DIV - 1)) begin
                div_q <= '0;
                state <= (bus.mode == 2'b10) ? GROW : STEP;
              end else begin
                div_q <= div_q + DIV_W'(1);
              end
            end
          end
          STEP: begin
            if (do_move) begin
              head_x_q     <= nxt_x;
              head_y_q     <= nxt_y;
              dir_q        <= nxt_dir;
              seg_x_q[0]   <= head_x_q;
              seg_y_q[0]   <= head_y_q;
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
              end
              step_valid_q <= 1'b1;
              ate_sheep_q  <= (bus.mode == 2'b01) && (nxt_x == tgt_x) && (nxt_y == tgt_y);
              hit_player_q <= (bus.mode == 2'b00) && (nxt_x == tgt_x) && (nxt_y == tgt_y);
            end
            state <= WAIT;
          end
          GROW: begin
            if (length_q < LEN_W'(MAX_LEN)) begin
              length_q <= length_q + LEN_W'(1);
              if (length_q == '0) begin
                seg_x_q[tail_idx] <= head_x_q;
                seg_y_q[tail_idx] <= head_y_q;
              end else begin
                seg_x_q[tail_idx] <= seg_x_q[last_idx];
                seg_y_q[tail_idx] <= seg_y_q[last_idx];
              end
            end
            state <= WAIT;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Segment readback: slots past the live body length read as zero.
  assign seg_in_range = (LEN_W'(bus.seg_sel) < length_q);
  assign bus.seg_x    = seg_in_range ? seg_x_q[bus.seg_sel] : '0;
  assign bus.seg_y    = seg_in_range ? seg_y_q[bus.seg_sel] : '0;

  assign bus.head_x     = head_x_q;
  assign bus.head_y     = head_y_q;
  assign bus.dir        = dir_q;
  assign bus.length     = length_q;
  assign bus.step_valid = step_valid_q;
  assign bus.ate_sheep  = ate_sheep_q;
  assign bus.hit_player = hit_player_q;
endmodule

// File: tb/tb_dragon_move_sched.sv
// Bench for the dragon movement scheduler: random and directed modes/targets against a queue-based body model.
// Latency: expected step events are queued at tick time and matched when step_valid appears.
// Backpressure: not applicable; ticks are spaced so each step completes before the next tick.
`timescale 1ns/1ps
module tb_dragon_move_sched;
  localparam int COORD_W  = 4;
  localparam int MAX_LEN  = 8;
  localparam int MOVE_DIV = 4;
  localparam int START_X  = 0;
  localparam int START_Y  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dragon_move_sched_if #(.COORD_W(COORD_W), .MAX_LEN(MAX_LEN)) bus ();

  dragon_move_sched #(
    .COORD_W (COORD_W),
    .MAX_LEN (MAX_LEN),
    .MOVE_DIV(MOVE_DIV),
    .START_X (START_X),
    .START_Y (START_Y)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int x;
    int y;
    int d;
    int ate;
    int hit;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int steps_seen = 0;
  int ate_seen = 0;
  int hit_seen = 0;

  // Reference model: head, last direction, tick count and the visible body as a list of tiles (head-adjacent first)
  int m_hx, m_hy, m_dir, m_len, m_cnt;
  int m_bx[$];
  int m_by[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hx = START_X;
    m_hy = START_Y;
    m_dir = 0;
    m_len = 0;
    m_cnt = 0;
    m_bx.delete();
    m_by.delete();
  endtask

  // One dragon step decision, from the behaviour rules directly
  task automatic model_step();
    int md, tx, ty, ox, oy;
    exp_t e;
    md = int'(bus.mode);
    if (md == 2) begin
      if (m_len < MAX_LEN) begin
        if (m_len == 0) begin
          m_bx.push_back(m_hx);
          m_by.push_back(m_hy);
        end else begin
          m_bx.push_back(m_bx[$]);
          m_by.push_back(m_by[$]);
        end
        m_len++;
      end
      return;
    end
    if (md == 3) return;
    tx = (md == 0) ? int'(bus.player_x) : int'(bus.sheep_x);
    ty = (md == 0) ? int'(bus.player_y) : int'(bus.sheep_y);
    if (m_hx == tx && m_hy == ty) return;
    ox = m_hx;
    oy = m_hy;
    if (m_hx != tx) begin
      if (tx > m_hx) begin m_hx++; m_dir = 0; end
      else begin m_hx--; m_dir = 1; end
    end else begin
      if (ty > m_hy) begin m_hy++; m_dir = 2; end
      else begin m_hy--; m_dir = 3; end
    end
    m_bx.push_front(ox);
    m_by.push_front(oy);
    if (m_bx.size() > m_len) begin
      void'(m_bx.pop_back());
      void'(m_by.pop_back());
    end
    e.x = m_hx;
    e.y = m_hy;
    e.d = m_dir;
    e.ate = (md == 1 && m_hx == tx && m_hy == ty) ? 1 : 0;
    e.hit = (md == 0 && m_hx == tx && m_hy == ty) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // One frame tick, spaced far enough apart that any resulting step has landed on return
  task automatic tick();
    @(negedge clk);
    m_cnt++;
    if (m_cnt == MOVE_DIV) begin
      m_cnt = 0;
      model_step();
    end
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic interval(input int n);
    repeat (n * MOVE_DIV) tick();
  endtask

  task automatic check_state();
    int ex, ey;
    check("head_x", bus.head_x, m_hx);
    check("head_y", bus.head_y, m_hy);
    check("dir", bus.dir, m_dir);
    check("length", bus.length, m_len);
    check("pending_steps", exp_q.size(), 0);
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.seg_sel = i[$clog2(MAX_LEN)-1:0];
      #1;
      ex = (i < m_len) ? m_bx[i] : 0;
      ey = (i < m_len) ? m_by[i] : 0;
      check("seg_x", bus.seg_x, ex);
      check("seg_y", bus.seg_y, ey);
    end
  endtask

  // Monitor: every step_valid must match the next queued move; pulses never appear without it
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.step_valid === 1'b1) begin
        steps_seen++;
        if (bus.ate_sheep === 1'b1) ate_seen++;
        if (bus.hit_player === 1'b1) hit_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_step: step_valid=1 head=(%0d,%0d) but no move was due", bus.head_x, bus.head_y);
        end else begin
          mon_e = exp_q.pop_front();
          check("step_head_x", bus.head_x, mon_e.x);
          check("step_head_y", bus.head_y, mon_e.y);
          check("step_dir", bus.dir, mon_e.d);
          check("step_ate_sheep", bus.ate_sheep, mon_e.ate);
          check("step_hit_player", bus.hit_player, mon_e.hit);
        end
      end else if (bus.ate_sheep !== 1'b0 || bus.hit_player !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_pulse: ate=%0d hit=%0d without step_valid", bus.ate_sheep, bus.hit_player);
      end
    end
  end

  initial begin
    int s0, r;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.frame_tick = 1'b0;
    bus.mode = 2'b00;
    bus.player_x = '0;
    bus.player_y = '0;
    bus.sheep_x = '0;
    bus.sheep_y = '0;
    bus.seg_sel = '0;
    model_reset();
    #12;
    check_state();
    check("reset_step_valid", bus.step_valid, 0);
    check("reset_ate", bus.ate_sheep, 0);
    check("reset_hit", bus.hit_player, 0);

    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);

    // Chase player along X to (3,0), then one more interval with nothing to do
    bus.player_x = 4'd3;
    bus.player_y = 4'd0;
    bus.mode = 2'b00;
    interval(1);
    check("p1_first_head_x", bus.head_x, 1);
    check("p1_first_dir", bus.dir, 0);
    check_state();
    interval(2);
    check("p1_head_x", bus.head_x, 3);
    check("p1_hits", hit_seen, 1);
    check_state();
    interval(1);
    check("p1_steps_after_arrival", steps_seen, 3);
    check("p1_hits_after_arrival", hit_seen, 1);
    check_state();

    // Grow ten times: saturates at MAX_LEN, no head movement
    bus.mode = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      interval(1);
      check("grow_length", bus.length, (k < MAX_LEN) ? k : MAX_LEN);
      check_state();
    end
    check("grow_no_steps", steps_seen, 3);

    // Chase player to (5,5) with a full body shifting behind
    bus.player_x = 4'd5;
    bus.player_y = 4'd5;
    bus.mode = 2'b00;
    for (int k = 0; k < 7; k++) begin
      interval(1);
      check_state();
    end
    check("chase_head_x", bus.head_x, 5);
    check("chase_head_y", bus.head_y, 5);

    // Chase sheep straight down -Y to (5,2)
    bus.sheep_x = 4'd5;
    bus.sheep_y = 4'd2;
    bus.mode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      interval(1);
      check_state();
    end
    check("sheep_head_y", bus.head_y, 2);
    check("sheep_dir", bus.dir, 3);
    check("sheep_ate_count", ate_seen, 1);

    // Hold mode: nothing moves for three intervals
    s0 = steps_seen;
    bus.mode = 2'b11;
    interval(3);
    check("hold_steps", steps_seen, s0);
    check_state();

    // Dropping enable mid-count restarts the divider
    bus.player_x = 4'd12;
    bus.player_y = 4'd9;
    bus.mode = 2'b00;
    tick();
    tick();
    @(negedge clk);
    bus.enable = 1'b0;
    m_cnt = 0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    s0 = steps_seen;
    repeat (3) tick();
    check("reenable_no_early_step", steps_seen, s0);
    tick();
    check("reenable_step", steps_seen, s0 + 1);
    check_state();

    // Reset asserted while the scheduler sits in STEP aborts the move
    repeat (MOVE_DIV - 1) tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_head_x", bus.head_x, START_X);
    check("abort_head_y", bus.head_y, START_Y);
    check("abort_length", bus.length, 0);
    check("abort_step_valid", bus.step_valid, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("abort_step_valid_later", bus.step_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_state();

    // Random modes and targets
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0 || k == 0) begin
        bus.player_x = COORD_W'($urandom_range(0, 15));
        bus.player_y = COORD_W'($urandom_range(0, 15));
        bus.sheep_x = COORD_W'($urandom_range(0, 15));
        bus.sheep_y = COORD_W'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 9);
      bus.mode = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      interval(1);
      check_state();
    end

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
